// File: rtl/speed_sequencer.sv
// Game-speed sequencer: shared countdown timebase, periodic ticks, level/rate stepping.
// Define SPEED_SEQ_WRAP_EN to wrap from MAX_LEVEL back to level 0 instead of saturating.
module speed_sequencer #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned BASE_RATE       = 1,
  parameter int unsigned RATE_STEP       = 1,
  parameter int unsigned TICKS_PER_LEVEL = 16,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned LEVEL_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  output logic               tick,
  output logic               half,
  output logic [LEVEL_W-1:0] level,
  output logic [25:0]        rate,
  output logic               level_up,
  output logic               busy,
  output logic               running
);

  localparam int unsigned        TcW      = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [TcW-1:0]     TcLast   = TcW'(TICKS_PER_LEVEL - 1);
  localparam logic [25:0]        Dividend = 26'(CLK_HZ);
  localparam logic [25:0]        BaseRate = 26'(BASE_RATE);
  localparam logic [25:0]        Step     = 26'(RATE_STEP);
  localparam logic [LEVEL_W-1:0] MaxLevel = LEVEL_W'(MAX_LEVEL);
  localparam logic [4:0]         LastIter = 5'd25;

  typedef enum logic [1:0] {StIdle, StCalc, StRun, StPause} state_e;

  state_e             state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [25:0]        rate_q;
  logic [25:0]        count_q;
  logic [25:0]        quot_q;
  logic [TcW-1:0]     tick_cnt_q;
  logic [25:0]        rem_q;
  logic [25:0]        dq_q;   // dividend bits shift out the top, quotient bits shift in below
  logic [4:0]         iter_q;

  // One restoring-division step per cycle; the divisor is the (frozen) current rate.
  logic [26:0] rem_shift;
  logic        rem_ge;
  logic [25:0] rem_next;
  logic [25:0] quo_next;

  assign rem_shift = {rem_q, dq_q[25]};
  assign rem_ge    = rem_shift >= {1'b0, rate_q};
  assign rem_next  = rem_ge ? (rem_shift[25:0] - rate_q) : rem_shift[25:0];
  assign quo_next  = {dq_q[24:0], rem_ge};

  logic [26:0] rate_sum;
  logic [25:0] rate_inc;

  assign rate_sum = {1'b0, rate_q} + {1'b0, Step};
  assign rate_inc = rate_sum[26] ? '1 : rate_sum[25:0];

  logic               level_room;
  logic               wrap;
  logic [LEVEL_W-1:0] level_nxt;
  logic [25:0]        rate_nxt;

`ifdef SPEED_SEQ_WRAP_EN
  assign level_room = 1'b1;
  assign wrap       = (level_q >= MaxLevel);
`else
  assign level_room = (level_q < MaxLevel);
  assign wrap       = 1'b0;
`endif

  assign level_nxt = wrap ? '0 : level_q + 1'b1;
  assign rate_nxt  = wrap ? BaseRate : rate_inc;

  logic last_tick;

  assign last_tick = (tick_cnt_q == TcLast);
  assign tick      = !reset && !stop && (state_q == StRun) && (count_q == '0) && !pause;
  assign level_up  = tick && last_tick && level_room;
  assign half      = (state_q == StRun) && (count_q <= (quot_q >> 1));
  assign busy      = (state_q == StCalc);
  assign running   = (state_q == StRun) || (state_q == StPause);
  assign level     = level_q;
  assign rate      = rate_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      level_q    <= '0;
      rate_q     <= BaseRate;
      count_q    <= '0;
      quot_q     <= '0;
      tick_cnt_q <= '0;
      rem_q      <= '0;
      dq_q       <= '0;
      iter_q     <= '0;
    end else if (stop) begin
      // Any divide in flight is simply dropped.
      state_q    <= StIdle;
      level_q    <= '0;
      rate_q     <= BaseRate;
      count_q    <= '0;
      tick_cnt_q <= '0;
      iter_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            level_q    <= '0;
            rate_q     <= BaseRate;
            tick_cnt_q <= '0;
            rem_q      <= '0;
            dq_q       <= Dividend;
            iter_q     <= '0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          rem_q  <= rem_next;
          dq_q   <= quo_next;
          iter_q <= iter_q + 5'd1;
          if (iter_q == LastIter) begin
            quot_q  <= quo_next;
            count_q <= quo_next;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (pause) begin
            state_q <= StPause;
          end else if (count_q == '0) begin
            count_q <= quot_q;
            if (last_tick) begin
              tick_cnt_q <= '0;
              if (level_room) begin
                level_q <= level_nxt;
                rate_q  <= rate_nxt;
                rem_q   <= '0;
                dq_q    <= Dividend;
                iter_q  <= '0;
                state_q <= StCalc;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end else begin
            count_q <= count_q - 26'd1;
          end
        end
        StPause: begin
          if (!pause) state_q <= StRun;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_sequencer.sv
// Scoreboarded random bench for speed_sequencer against a behavioural per-cycle model.
module tb_speed_sequencer;

  localparam int CLK_HZ = 100;
  localparam int BASE   = 10;
  localparam int STEP   = 10;
  localparam int TPL    = 2;
  localparam int MAXL   = 2;

  localparam int M_IDLE  = 0;
  localparam int M_CALC  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        tick, half, level_up, busy, running;
  logic [3:0]  level;
  logic [25:0] rate;

  speed_sequencer #(
    .CLK_HZ(CLK_HZ), .BASE_RATE(BASE), .RATE_STEP(STEP),
    .TICKS_PER_LEVEL(TPL), .MAX_LEVEL(MAXL), .LEVEL_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .tick(tick), .half(half), .level(level), .rate(rate), .level_up(level_up),
    .busy(busy), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tick;
    logic        half;
    logic        level_up;
    logic        busy;
    logic        running;
    logic [3:0]  level;
    logic [25:0] rate;
  } obs_t;

  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   timeout_pending = 0;

  // Model state
  int m_mode = M_IDLE;
  int m_calc_left = 0;
  int m_cnt = 0;
  int m_q = 0;
  int m_lvl = 0;
  int m_rate = BASE;
  int m_tc = 0;

  task automatic step(input bit r, input bit s, input bit p, input bit t);
    obs_t e;
    bit   tk, last, room;
    @(posedge clk);
    #1;
    reset = r; start = s; pause = p; stop = t;
    tk   = !r && !t && m_mode == M_RUN && m_cnt == 0 && !p;
    last = (m_tc == TPL - 1);
`ifdef SPEED_SEQ_WRAP_EN
    room = 1;
`else
    room = (m_lvl < MAXL);
`endif
    e.tick     = tk;
    e.level_up = tk && last && room;
    e.half     = (m_mode == M_RUN) && (m_cnt <= m_q / 2);
    e.busy     = (m_mode == M_CALC);
    e.running  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.level    = 4'(m_lvl);
    e.rate     = 26'(m_rate);
    sb.push_back(e);
    if (r) begin
      m_mode = M_IDLE; m_lvl = 0; m_rate = BASE; m_cnt = 0; m_q = 0; m_tc = 0;
    end else if (t) begin
      m_mode = M_IDLE; m_lvl = 0; m_rate = BASE; m_cnt = 0; m_tc = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          m_lvl = 0; m_rate = BASE; m_tc = 0; m_mode = M_CALC; m_calc_left = 26;
        end
        M_CALC: begin
          m_calc_left--;
          if (m_calc_left == 0) begin
            m_q = CLK_HZ / m_rate; m_cnt = m_q; m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (p) m_mode = M_PAUSE;
          else if (tk) begin
            m_cnt = m_q;
            if (last) begin
              m_tc = 0;
              if (room) begin
                if (m_lvl >= MAXL) begin
                  m_lvl = 0; m_rate = BASE;
                end else begin
                  m_lvl++; m_rate = m_rate + STEP;
                  if (m_rate > 26'h3ff_ffff) m_rate = 26'h3ff_ffff;
                end
                m_mode = M_CALC; m_calc_left = 26;
              end
            end else m_tc++;
          end else m_cnt--;
        end
        default: if (!p) m_mode = M_RUN;
      endcase
    end
  endtask

  // Monitor: pops one expected observation per cycle and compares.
  always @(negedge clk) begin
    obs_t act, exp_o;
    cyc++;
    if (timeout_pending) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_bound: got no RUN count==0 cycle within budget, required one");
      timeout_pending = 0;
    end
    if (sb.size() != 0) begin
      exp_o = sb.pop_front();
      act = '{tick: tick, half: half, level_up: level_up, busy: busy, running: running,
              level: level, rate: rate};
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("FAIL outputs @cyc %0d: got tick=%b half=%b lu=%b busy=%b run=%b lvl=%0d rate=%0d, required tick=%b half=%b lu=%b busy=%b run=%b lvl=%0d rate=%0d",
                 cyc, act.tick, act.half, act.level_up, act.busy, act.running, act.level,
                 act.rate, exp_o.tick, exp_o.half, exp_o.level_up, exp_o.busy, exp_o.running,
                 exp_o.level, exp_o.rate);
      end
    end
  end

  initial begin
    bit p_lvl;
    bit found;
    // Reset held for 3 cycles
    repeat (3) step(1, 0, 0, 0);
    // Start, run up through level 2 and past saturation
    step(0, 1, 0, 0);
    repeat (250) step(0, 0, 0, 0);
    // Pause landing exactly on a count==0 RUN cycle, held 5 cycles
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_mode == M_RUN && m_cnt == 0) found = 1;
      else step(0, 0, 0, 0);
    end
    if (!found) timeout_pending = 1;
    repeat (5) step(0, 0, 1, 0);
    repeat (30) step(0, 0, 0, 0);
    // Stop mid-CALC, then restart with a full divide
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (9) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    repeat (80) step(0, 0, 0, 0);
    // Randomized control traffic
    p_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) p_lvl = !p_lvl;
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 7) == 0), p_lvl,
           ($urandom_range(0, 199) == 0));
    end
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
